ugt_window_peak8: RTL and testbench



---
 rtl/ugt_window_peak8.sv | 108 ++++++++++
 tb/tb_ugt_window_peak8.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ugt_window_peak8.sv
// Streaming windowed peak detector: tracks the unsigned maximum of each window of
// samples and hands out peak value, peak position and sample count on a valid/ready port.
module ugt_window_peak8 #(
  parameter int WIDTH     = 8,
  parameter int WINDOW    = 16,
  parameter int IDX_WIDTH = $clog2(WINDOW)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [WIDTH-1:0]     I,
  input  logic                 I_valid,
  output logic                 I_ready,
  input  logic                 FLUSH,
  output logic [WIDTH-1:0]     O,
  output logic [IDX_WIDTH-1:0] O_index,
  output logic [IDX_WIDTH:0]   O_count,
  output logic                 O_valid,
  input  logic                 O_ready
);

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_POS = IDX_WIDTH'(WINDOW - 1);

  state_t               state_q, state_d;
  logic [IDX_WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0]     max_q, max_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]     peak_q, peak_d;
  logic [IDX_WIDTH-1:0] peakIdx_q, peakIdx_d;
  logic [IDX_WIDTH:0]   peakCnt_q, peakCnt_d;

  logic accept;
  logic isGreater;
  logic closeWin;

  assign I_ready = (state_q == ACCUM);
  assign O_valid = (state_q == EMIT);
  assign O       = peak_q;
  assign O_index = peakIdx_q;
  assign O_count = peakCnt_q;

  assign accept    = I_valid & I_ready;
  // Strict unsigned greater-than so that ties keep the earliest position.
  assign isGreater = (I > max_q);
  assign closeWin  = (state_q == ACCUM) &&
                     ((accept && (count_q == LAST_POS)) ||
                      (FLUSH && ((count_q != '0) || accept)));

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    max_d     = max_q;
    idx_d     = idx_q;
    peak_d    = peak_q;
    peakIdx_d = peakIdx_q;
    peakCnt_d = peakCnt_q;

    if (state_q == ACCUM) begin
      if (accept) begin
        if (count_q == '0) begin
          max_d = I;
          idx_d = '0;
        end else if (isGreater) begin
          max_d = I;
          idx_d = count_q;
        end
        count_d = count_q + 1'b1;
      end
      // The closing sample is folded in via max_d/idx_d before the result is captured.
      if (closeWin) begin
        peak_d    = max_d;
        peakIdx_d = idx_d;
        peakCnt_d = (IDX_WIDTH+1)'(count_q) + (IDX_WIDTH+1)'(accept);
        count_d   = '0;
        state_d   = EMIT;
      end
    end else begin
      if (O_ready) begin
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ACCUM;
      count_q   <= '0;
      max_q     <= '0;
      idx_q     <= '0;
      peak_q    <= '0;
      peakIdx_q <= '0;
      peakCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      max_q     <= max_d;
      idx_q     <= idx_d;
      peak_q    <= peak_d;
      peakIdx_q <= peakIdx_d;
      peakCnt_q <= peakCnt_d;
    end
  end

endmodule

// File: tb/tb_ugt_window_peak8.sv
// Bench for ugt_window_peak8 (WINDOW=4): directed literal scenarios followed by a
// randomized run, all checked against a queue-based window model every cycle.
module tb_ugt_window_peak8;

  localparam int WIDTH  = 8;
  localparam int WINDOW = 4;
  localparam int IDXW   = $clog2(WINDOW);

  logic             CLK;
  logic             RESET;
  logic [WIDTH-1:0] I;
  logic             I_valid;
  logic             I_ready;
  logic             FLUSH;
  logic [WIDTH-1:0] O;
  logic [IDXW-1:0]  O_index;
  logic [IDXW:0]    O_count;
  logic             O_valid;
  logic             O_ready;

  int testsRun = 0;
  int testsFailed = 0;
  bit checkEn = 0;

  // Reference model state: samples of the open window and the pending result.
  byte unsigned winQ[$];
  bit           mEmit;
  int           mPeak, mIdx, mCnt;

  ugt_window_peak8 #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
    .CLK(CLK), .RESET(RESET), .I(I), .I_valid(I_valid), .I_ready(I_ready),
    .FLUSH(FLUSH), .O(O), .O_index(O_index), .O_count(O_count),
    .O_valid(O_valid), .O_ready(O_ready)
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Model advances on the same edge as the DUT, from the inputs held stable across it.
  always @(posedge CLK) begin
    if (RESET) begin
      winQ.delete();
      mEmit = 0;
      mPeak = 0;
      mIdx  = 0;
      mCnt  = 0;
    end else if (!mEmit) begin
      if (I_valid) winQ.push_back(I);
      if ((winQ.size() == WINDOW) || (FLUSH && winQ.size() > 0)) begin
        mPeak = winQ[0];
        mIdx  = 0;
        for (int k = 1; k < winQ.size(); k++) begin
          if (winQ[k] > mPeak) begin
            mPeak = winQ[k];
            mIdx  = k;
          end
        end
        mCnt = winQ.size();
        winQ.delete();
        mEmit = 1;
      end
    end else if (O_ready) begin
      mEmit = 0;
    end
  end

  always @(negedge CLK) begin
    if (checkEn) begin
      checkOutput("model I_ready", int'(I_ready), int'(!mEmit));
      checkOutput("model O_valid", int'(O_valid), int'(mEmit));
      checkOutput("model O", int'(O), mPeak);
      checkOutput("model O_index", int'(O_index), mIdx);
      checkOutput("model O_count", int'(O_count), mCnt);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input bit valid, input int data, input bit flush);
    I_valid = valid;
    I       = WIDTH'(data);
    FLUSH   = flush;
    step();
    I_valid = 0;
    FLUSH   = 0;
  endtask

  task automatic checkResult(input string name, input int peak, input int idx, input int cnt);
    checkOutput({name, " O_valid"}, int'(O_valid), 1);
    checkOutput({name, " O"}, int'(O), peak);
    checkOutput({name, " O_index"}, int'(O_index), idx);
    checkOutput({name, " O_count"}, int'(O_count), cnt);
  endtask

  initial begin
    RESET = 1; I = 0; I_valid = 0; FLUSH = 0; O_ready = 1;
    step();
    step();
    checkOutput("reset O_valid", int'(O_valid), 0);
    checkOutput("reset I_ready", int'(I_ready), 1);
    checkOutput("reset O", int'(O), 0);
    checkOutput("reset O_count", int'(O_count), 0);
    RESET = 0;
    checkEn = 1;

    // Basic window with a tie: earliest 200 wins.
    applyStimulus(1, 3, 0);
    applyStimulus(1, 200, 0);
    applyStimulus(1, 7, 0);
    applyStimulus(1, 200, 0);
    checkResult("basic", 200, 1, 4);
    checkOutput("basic I_ready", int'(I_ready), 0);
    step();
    checkOutput("basic I_ready after", int'(I_ready), 1);
    checkOutput("basic O_valid after", int'(O_valid), 0);

    // Unsigned ordering and the all-zero window.
    applyStimulus(1, 'h7F, 0);
    applyStimulus(1, 'h80, 0);
    applyStimulus(1, 'h01, 0);
    applyStimulus(1, 'h00, 0);
    checkResult("unsigned", 'h80, 1, 4);
    step();
    for (int k = 0; k < 4; k++) applyStimulus(1, 0, 0);
    checkResult("zeros", 0, 0, 4);
    step();

    // Backpressure, then a fresh window with a smaller peak.
    O_ready = 0;
    applyStimulus(1, 5, 0);
    applyStimulus(1, 6, 0);
    applyStimulus(1, 7, 0);
    applyStimulus(1, 8, 0);
    for (int k = 0; k < 5; k++) begin
      I_valid = 1;
      I = 99;
      step();
      checkResult("hold", 8, 3, 4);
      checkOutput("hold I_ready", int'(I_ready), 0);
    end
    I_valid = 0;
    O_ready = 1;
    step();
    checkOutput("release I_ready", int'(I_ready), 1);
    applyStimulus(1, 2, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    checkResult("fresh", 2, 0, 4);
    step();

    // Flush cases.
    applyStimulus(1, 10, 0);
    applyStimulus(1, 9, 0);
    applyStimulus(0, 0, 1);
    checkResult("flush alone", 10, 0, 2);
    step();
    applyStimulus(1, 40, 0);
    applyStimulus(1, 45, 0);
    applyStimulus(1, 50, 1);
    checkResult("flush with sample", 50, 2, 3);
    step();
    applyStimulus(0, 0, 1);
    checkOutput("empty flush O_valid", int'(O_valid), 0);
    step();
    checkOutput("empty flush O_valid later", int'(O_valid), 0);

    // Reset mid-window, then reset during EMIT.
    applyStimulus(1, 1, 0);
    applyStimulus(1, 2, 0);
    RESET = 1;
    step();
    RESET = 0;
    checkOutput("midreset O_valid", int'(O_valid), 0);
    O_ready = 0;
    applyStimulus(1, 1, 0);
    applyStimulus(1, 2, 0);
    applyStimulus(1, 3, 0);
    applyStimulus(1, 4, 0);
    checkResult("after reset", 4, 3, 4);
    RESET = 1;
    step();
    RESET = 0;
    checkOutput("emit reset O_valid", int'(O_valid), 0);
    checkOutput("emit reset O", int'(O), 0);
    checkOutput("emit reset O_index", int'(O_index), 0);
    checkOutput("emit reset O_count", int'(O_count), 0);

    // Randomized traffic, narrow value ranges included to provoke ties.
    for (int n = 0; n < 3000; n++) begin
      I_valid = ($urandom_range(0, 3) != 0);
      I       = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom_range(0, 255))
                                            : WIDTH'($urandom_range(126, 130));
      FLUSH   = ($urandom_range(0, 9) == 0);
      O_ready = ($urandom_range(0, 4) < 3);
      RESET   = ($urandom_range(0, 99) == 0);
      step();
    end
    I_valid = 0; FLUSH = 0; RESET = 0; O_ready = 1;
    step();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
